task_sequencer: RTL and testbench

- Initiator for the start/en/done task handshake used by the flag-processing task blocks (sink check, aggregation, etc.).
- Runs tasks 0..N_TASKS-1 in order, one at a time, and returns each task to idle after it finishes.
- Owns the single shared register-bank port and muxes it to whichever task holds the grant.
- Sits in top-level control between the system "run" request and the task array.

---
 rtl/task_sequencer_pkg.sv | 30 +++
 rtl/task_sequencer_if.sv | 51 +++++
 rtl/task_sequencer_mem_port_mux.sv | 37 +++
 rtl/task_sequencer.sv | 158 +++++++++++++++
 tb/tb_task_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/task_sequencer_pkg.sv
// task_sequencer_pkg: shared definitions for the task sequencer slice.
// Holds the FSM state encoding, the default register-bank word width, the
// flag register addresses shared with the task blocks and a small helper
// that identifies the states in which the granted task owns the bank port.
package task_sequencer_pkg;

    localparam int WORD_WIDTH_DEF = 16;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_FINISH  = 3'd6
    } seq_state_t;

    // Flag registers in the shared bank that the task blocks read and write
    localparam logic [WORD_WIDTH_DEF-1:0] ADDR_AM_I_SINK       = 16'h0000;
    localparam logic [WORD_WIDTH_DEF-1:0] ADDR_FOR_AGGREGATION = 16'h0002;

    // The granted task may write the bank only while it is started, running
    // or being released; everywhere else its writes are dropped.
    function automatic logic bus_owned(input seq_state_t s);
        return (s == ST_START) || (s == ST_WAIT) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/task_sequencer_if.sv
// task_sequencer_if: start/en/done handshake plus the shared register-bank
// port between the sequencer (master) and the task array / bank (slave).
// Task address and data buses are flattened, task i at [i*WORD_WIDTH +: WORD_WIDTH].
interface task_sequencer_if
    import task_sequencer_pkg::*;
#(
    parameter int N_TASKS    = 4,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
);

    logic [N_TASKS-1:0]            start_vec;
    logic [N_TASKS-1:0]            en_vec;
    logic [N_TASKS-1:0]            done_vec;
    logic [N_TASKS*WORD_WIDTH-1:0] task_addr;
    logic [N_TASKS-1:0]            task_wr_en;
    logic [N_TASKS*WORD_WIDTH-1:0] task_wdata;
    logic [WORD_WIDTH-1:0]         task_rdata;
    logic [WORD_WIDTH-1:0]         mem_addr;
    logic                          mem_wr_en;
    logic [WORD_WIDTH-1:0]         mem_wdata;
    logic [WORD_WIDTH-1:0]         mem_rdata;

    modport master (
        output start_vec,
        output en_vec,
        input  done_vec,
        input  task_addr,
        input  task_wr_en,
        input  task_wdata,
        output task_rdata,
        output mem_addr,
        output mem_wr_en,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  start_vec,
        input  en_vec,
        output done_vec,
        output task_addr,
        output task_wr_en,
        output task_wdata,
        input  task_rdata,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/task_sequencer_mem_port_mux.sv
// mem_port_mux: N-to-1 selection of the register-bank address, write data
// and write enable by the granted task index. The write enable is gated so
// that only a task that currently owns the port can write.
module mem_port_mux
    import task_sequencer_pkg::*;
#(
    parameter int N_TASKS    = 4,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic [3:0]                    cur_task,
    input  logic                          bus_active,
    input  logic [N_TASKS*WORD_WIDTH-1:0] task_addr,
    input  logic [N_TASKS-1:0]            task_wr_en,
    input  logic [N_TASKS*WORD_WIDTH-1:0] task_wdata,
    output logic [WORD_WIDTH-1:0]         mem_addr,
    output logic                          mem_wr_en,
    output logic [WORD_WIDTH-1:0]         mem_wdata
);

    logic sel_wr_en;

    // Pick the granted task's bus; an out-of-range index selects nothing
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        sel_wr_en = 1'b0;
        for (int i = 0; i < N_TASKS; i++) begin
            if (cur_task == 4'(i)) begin
                mem_addr  = task_addr[i*WORD_WIDTH +: WORD_WIDTH];
                mem_wdata = task_wdata[i*WORD_WIDTH +: WORD_WIDTH];
                sel_wr_en = task_wr_en[i];
            end
        end
        mem_wr_en = sel_wr_en & bus_active;
    end

endmodule

// File: rtl/task_sequencer.sv
// task_sequencer: runs tasks 0..N_TASKS-1 in order over the start/en/done
// handshake, one at a time, and grants the single register-bank port to the
// running task. All control outputs are registered and line up with the FSM
// state; the bank port mux is combinational.
// Optional build macro SEQ_TIMEOUT_EN adds a per-task WAIT watchdog that
// forces release after TIMEOUT_CYCLES and sets a sticky timeout_err bit.
module task_sequencer
    import task_sequencer_pkg::*;
#(
    parameter int N_TASKS        = 4,
    parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  run,
    task_sequencer_if.master      bus,
    output logic                  busy,
    output logic                  pass_done,
    output logic [3:0]            cur_task,
    output logic [N_TASKS-1:0]    timeout_err
);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [3:0]         cur_next;
    logic [N_TASKS-1:0] start_d;
    logic [N_TASKS-1:0] en_d;
    logic               busy_d;
    logic               pass_d;
    logic               cur_done;
    logic               last_task;
    logic               bus_active;

    function automatic logic [N_TASKS-1:0] task_onehot(input logic [3:0] idx);
        logic [N_TASKS-1:0] v;
        v = '0;
        for (int i = 0; i < N_TASKS; i++) begin
            if (idx == 4'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Done of the granted task only; other tasks' done lines are ignored
    always_comb begin
        cur_done = 1'b0;
        for (int i = 0; i < N_TASKS; i++) begin
            if (cur_task == 4'(i)) cur_done = bus.done_vec[i];
        end
    end

    assign last_task = (cur_task == 4'(N_TASKS - 1));

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // A coinciding done wins, so the timeout only fires with done still low
    assign timeout_hit = (state == ST_WAIT) && !cur_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter, held at zero outside WAIT so it starts fresh each entry
    always_ff @(posedge clock) begin
        if (!nrst || (state != ST_WAIT)) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // Sticky per-task watchdog flags, cleared only by reset
    always_ff @(posedge clock) begin
        if (!nrst)            timeout_err <= '0;
        else if (timeout_hit) timeout_err <= timeout_err | task_onehot(cur_task);
    end
`else
    assign timeout_err = '0;
`endif

    // Next-state and next-output decode; outputs are derived from the next
    // state so that the registered pulses coincide with their states
    always_comb begin
        state_next = state;
        cur_next   = cur_task;
        case (state)
            ST_INIT:    state_next = ST_IDLE;
            ST_IDLE: begin
                if (run) begin
                    cur_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (cur_done) state_next = ST_RELEASE;
`ifdef SEQ_TIMEOUT_EN
                else if (timeout_hit) state_next = ST_RELEASE;
`endif
            end
            ST_RELEASE: state_next = ST_NEXT;
            ST_NEXT: begin
                if (last_task) begin
                    state_next = ST_FINISH;
                end else begin
                    cur_next   = cur_task + 4'd1;
                    state_next = ST_START;
                end
            end
            ST_FINISH:  state_next = ST_IDLE;
            default:    state_next = ST_INIT;
        endcase

        start_d = (state_next == ST_START) ? task_onehot(cur_next) : '0;
        // INIT releases every task at once to resynchronise the array
        if (state == ST_INIT)                en_d = '1;
        else if (state_next == ST_RELEASE)   en_d = task_onehot(cur_next);
        else                                 en_d = '0;
        busy_d = (state_next == ST_START) || (state_next == ST_WAIT) ||
                 (state_next == ST_RELEASE) || (state_next == ST_NEXT);
        pass_d = (state_next == ST_FINISH);
    end

    // State and registered control outputs; reset aborts any pass in flight
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state         <= ST_INIT;
            cur_task      <= '0;
            bus.start_vec <= '0;
            bus.en_vec    <= '0;
            busy          <= 1'b0;
            pass_done     <= 1'b0;
        end else begin
            state         <= state_next;
            cur_task      <= cur_next;
            bus.start_vec <= start_d;
            bus.en_vec    <= en_d;
            busy          <= busy_d;
            pass_done     <= pass_d;
        end
    end

    assign bus_active     = bus_owned(state);
    assign bus.task_rdata = bus.mem_rdata;

    mem_port_mux #(
        .N_TASKS    (N_TASKS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_mem_port_mux (
        .cur_task   (cur_task),
        .bus_active (bus_active),
        .task_addr  (bus.task_addr),
        .task_wr_en (bus.task_wr_en),
        .task_wdata (bus.task_wdata),
        .mem_addr   (bus.mem_addr),
        .mem_wr_en  (bus.mem_wr_en),
        .mem_wdata  (bus.mem_wdata)
    );

endmodule

// File: tb/tb_task_sequencer.sv
// tb_task_sequencer: directed bench for task_sequencer with two tasks.
// A small task model raises done a programmable number of cycles after its
// start pulse and drops it on its en pulse. Expected cycle positions are
// hand-computed from the per-task cost START+WAIT(D)+RELEASE+NEXT.
module tb_task_sequencer;
    import task_sequencer_pkg::*;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int TO = 10;

    logic          clock = 1'b0;
    logic          nrst  = 1'b0;
    logic          run   = 1'b0;
    logic          busy;
    logic          pass_done;
    logic [3:0]    cur_task;
    logic [N-1:0]  timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    task_sequencer_if #(.N_TASKS(N), .WORD_WIDTH(W)) bus();

    task_sequencer #(
        .N_TASKS        (N),
        .WORD_WIDTH     (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .nrst        (nrst),
        .run         (run),
        .bus         (bus),
        .busy        (busy),
        .pass_done   (pass_done),
        .cur_task    (cur_task),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    // Task model
    logic [N-1:0] model_done = '0;
    logic [N-1:0] active     = '0;
    logic [N-1:0] force_done = '0;
    logic [N-1:0] hang       = '0;
    int           dly [N];
    int           age [N];

    assign bus.done_vec = model_done | force_done;

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (bus.en_vec[i]) begin
                active[i]     <= 1'b0;
                model_done[i] <= 1'b0;
            end else if (bus.start_vec[i]) begin
                active[i]     <= 1'b1;
                age[i]        <= 1;
                model_done[i] <= !hang[i] && (dly[i] <= 1);
            end else if (active[i]) begin
                age[i]        <= age[i] + 1;
                model_done[i] <= !hang[i] && (age[i] + 1 >= dly[i]);
            end
        end
    end

    task automatic test_reset();
        int ones;
        int partial;
        nrst = 1'b0;
        run  = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({bus.start_vec, bus.en_vec, busy, pass_done, cur_task, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got start=%b en=%b busy=%b pd=%b cur=%0d err=%b exp all 0",
                     bus.start_vec, bus.en_vec, busy, pass_done, cur_task, timeout_err);
        end
        nrst    = 1'b1;
        ones    = 0;
        partial = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (bus.en_vec === 2'b11) ones++;
            else if (bus.en_vec !== 2'b00) partial++;
        end
        n_tests++;
        if (ones != 1 || partial != 0) begin
            n_fail++;
            $display("FAIL init_en_pulse got all_ones_cycles=%0d partial=%0d exp 1 and 0", ones, partial);
        end
        n_tests++;
        if ({bus.start_vec, bus.en_vec, busy, pass_done, cur_task} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_init got start=%b en=%b busy=%b pd=%b cur=%0d exp all 0",
                     bus.start_vec, bus.en_vec, busy, pass_done, cur_task);
        end
    endtask

    task automatic test_pass();
        logic [1:0] es, ee;
        logic       eb, ep;
        logic [3:0] ec;
        dly[0] = 3;
        dly[1] = 3;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            es = (c == 1) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
            ee = (c == 5) ? 2'b01 : (c == 11) ? 2'b10 : 2'b00;
            eb = (c >= 1 && c <= 12);
            ep = (c == 13);
            ec = (c >= 7) ? 4'd1 : 4'd0;
            n_tests++;
            if ({bus.start_vec, bus.en_vec, busy, pass_done, cur_task} !== {es, ee, eb, ep, ec}) begin
                n_fail++;
                $display("FAIL pass c=%0d got start=%b en=%b busy=%b pd=%b cur=%0d exp start=%b en=%b busy=%b pd=%b cur=%0d",
                         c, bus.start_vec, bus.en_vec, busy, pass_done, cur_task, es, ee, eb, ep, ec);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_mem_mux();
        dly[0] = 6;
        dly[1] = 3;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 3) begin
                bus.task_addr  = {16'h0005, ADDR_FOR_AGGREGATION};
                bus.task_wdata = {16'hBEEF, 16'h0001};
                bus.task_wr_en = 2'b11;
                bus.mem_rdata  = 16'h1234;
                #1;
                n_tests++;
                if ({bus.mem_addr, bus.mem_wdata, bus.mem_wr_en} !== {16'h0002, 16'h0001, 1'b1}) begin
                    n_fail++;
                    $display("FAIL mem_write_t0 got addr=%h wdata=%h we=%b exp addr=0002 wdata=0001 we=1",
                             bus.mem_addr, bus.mem_wdata, bus.mem_wr_en);
                end
                n_tests++;
                if (bus.task_rdata !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL rdata_bcast got %h exp 1234", bus.task_rdata);
                end
            end
            if (c == 4) begin
                bus.task_wr_en = 2'b10;
                #1;
                n_tests++;
                if (bus.mem_wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mem_we_other_task got %b exp 0", bus.mem_wr_en);
                end
                bus.task_wr_en = 2'b11;
            end
            if (c == 8) begin
                #1;
                n_tests++;
                if (bus.mem_wr_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mem_we_release got %b exp 1", bus.mem_wr_en);
                end
            end
            if (c == 9) begin
                #1;
                n_tests++;
                if (bus.mem_wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mem_we_next got %b exp 0", bus.mem_wr_en);
                end
            end
            if (c == 11) begin
                bus.task_wr_en = 2'b01;
                #1;
                n_tests++;
                if ({bus.mem_addr, bus.mem_wr_en} !== {16'h0005, 1'b0}) begin
                    n_fail++;
                    $display("FAIL mem_t1_grant got addr=%h we=%b exp addr=0005 we=0", bus.mem_addr, bus.mem_wr_en);
                end
            end
            if (c == 12) begin
                bus.task_wr_en = 2'b10;
                #1;
                n_tests++;
                if ({bus.mem_wdata, bus.mem_wr_en} !== {16'hBEEF, 1'b1}) begin
                    n_fail++;
                    $display("FAIL mem_write_t1 got wdata=%h we=%b exp wdata=beef we=1", bus.mem_wdata, bus.mem_wr_en);
                end
            end
            if (c == 16) begin
                n_tests++;
                if (pass_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mem_pass_done c=16 got %b exp 1", pass_done);
                end
            end
            if (c == 17) begin
                bus.task_wr_en = 2'b11;
                bus.mem_rdata  = 16'hABCD;
                #1;
                n_tests++;
                if ({bus.mem_wr_en, bus.task_rdata} !== {1'b0, 16'hABCD}) begin
                    n_fail++;
                    $display("FAIL mem_idle got we=%b rdata=%h exp we=0 rdata=abcd", bus.mem_wr_en, bus.task_rdata);
                end
                bus.task_wr_en = '0;
                bus.task_addr  = '0;
                bus.task_wdata = '0;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_ignore_other_done();
        logic [1:0] ee;
        logic       ep;
        logic [3:0] ec;
        dly[0] = 5;
        dly[1] = 2;
        force_done = 2'b10;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            ee = (c == 7) ? 2'b01 : (c == 12) ? 2'b10 : 2'b00;
            ep = (c == 14);
            ec = (c >= 9) ? 4'd1 : 4'd0;
            n_tests++;
            if ({bus.en_vec, pass_done, cur_task} !== {ee, ep, ec}) begin
                n_fail++;
                $display("FAIL ignore_done c=%0d got en=%b pd=%b cur=%0d exp en=%b pd=%b cur=%0d",
                         c, bus.en_vec, pass_done, cur_task, ee, ep, ec);
            end
            if (c == 7) force_done = 2'b00;
            @(negedge clock);
        end
        force_done = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [1:0] es;
        logic       eb, ep;
        dly[0] = 1;
        dly[1] = 1;
        run = 1'b1;
        @(negedge clock);
        for (int c = 1; c <= 22; c++) begin
            es = (c == 1 || c == 11) ? 2'b01 : (c == 5 || c == 15) ? 2'b10 : 2'b00;
            eb = (c >= 1 && c <= 8) || (c >= 11 && c <= 18);
            ep = (c == 9 || c == 19);
            n_tests++;
            if ({bus.start_vec, busy, pass_done} !== {es, eb, ep}) begin
                n_fail++;
                $display("FAIL b2b c=%0d got start=%b busy=%b pd=%b exp start=%b busy=%b pd=%b",
                         c, bus.start_vec, busy, pass_done, es, eb, ep);
            end
            if (c == 11) run = 1'b0;
            if (c == 14) run = 1'b1;
            if (c == 15) run = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_mid_reset();
        int  ones;
        int  partial;
        bit  seen;
        dly[0] = 3;
        dly[1] = 3;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        repeat (8) @(negedge clock);
        n_tests++;
        if ({cur_task, busy} !== {4'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_pre got cur=%0d busy=%b exp cur=1 busy=1", cur_task, busy);
        end
        nrst = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({bus.start_vec, bus.en_vec, busy, pass_done, cur_task} !== '0) begin
            n_fail++;
            $display("FAIL midrst_values got start=%b en=%b busy=%b pd=%b cur=%0d exp all 0",
                     bus.start_vec, bus.en_vec, busy, pass_done, cur_task);
        end
        nrst    = 1'b1;
        ones    = 0;
        partial = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (bus.en_vec === 2'b11) ones++;
            else if (bus.en_vec !== 2'b00) partial++;
        end
        n_tests++;
        if (ones != 1 || partial != 0) begin
            n_fail++;
            $display("FAIL midrst_en_pulse got all_ones_cycles=%0d partial=%0d exp 1 and 0", ones, partial);
        end
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        n_tests++;
        if ({bus.start_vec, cur_task} !== {2'b01, 4'd0}) begin
            n_fail++;
            $display("FAIL midrst_restart got start=%b cur=%0d exp start=01 cur=0", bus.start_vec, cur_task);
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            if (pass_done === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midrst_pass_done got none within 40 cycles exp pulse");
        end
        @(negedge clock);
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        dly[0] = 3;
        dly[1] = 2;
        hang   = 2'b01;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 11) begin
                n_tests++;
                if ({bus.en_vec, timeout_err} !== {2'b00, 2'b00}) begin
                    n_fail++;
                    $display("FAIL timeout_early got en=%b err=%b exp en=00 err=00", bus.en_vec, timeout_err);
                end
            end
            if (c == 12) begin
                n_tests++;
                if ({bus.en_vec, timeout_err} !== {2'b01, 2'b01}) begin
                    n_fail++;
                    $display("FAIL timeout_fire got en=%b err=%b exp en=01 err=01", bus.en_vec, timeout_err);
                end
            end
            if (c == 14) begin
                n_tests++;
                if (bus.start_vec !== 2'b10) begin
                    n_fail++;
                    $display("FAIL timeout_t1_start got %b exp 10", bus.start_vec);
                end
            end
            if (c == 19) begin
                n_tests++;
                if ({pass_done, timeout_err} !== {1'b1, 2'b01}) begin
                    n_fail++;
                    $display("FAIL timeout_pass got pd=%b err=%b exp pd=1 err=01", pass_done, timeout_err);
                end
            end
            @(negedge clock);
        end
        hang = 2'b00;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        dly[0] = 3;
        dly[1] = 3;
        bus.task_addr  = '0;
        bus.task_wdata = '0;
        bus.task_wr_en = '0;
        bus.mem_rdata  = '0;
        test_reset();
        test_pass();
        test_mem_mux();
        test_ignore_other_done();
        test_back_to_back();
        test_mid_reset();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
